wb_mem_arbiter: RTL and testbench
=================================

# wb_mem_arbiter

Two-master Wishbone B3 arbiter that shares the single verification memory slave between the Ethernet MAC DMA master (M0) and a host/backdoor master (M1). It sits between the MAC's `m_wb_*` bus and the memory-model interface. It grants one master at a time, holds the grant for a full `cyc` (including incrementing bursts) and rotates priority round-robin. An optional watchdog terminates stalled cycles with an error.

## Interface
- `TIMEOUT`, 256: cycles of `stb` without slave `ack`/`err` before watchdog error (watchdog build only); legal range 2..65535.
- `wb_clk` in 1: bus clock, all logic on rising edge.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `m0_wb_adr_i`/`m1_wb_adr_i` in 32: master address.
- `m0_wb_sel_i`/`m1_wb_sel_i` in 4: byte selects.
- `m0_wb_we_i`/`m1_wb_we_i` in 1: write enable.
- `m0_wb_dat_i`/`m1_wb_dat_i` in 32: write data from master.
- `m0_wb_cyc_i`/`m1_wb_cyc_i` in 1: cycle request.
- `m0_wb_stb_i`/`m1_wb_stb_i` in 1: strobe.
- `m0_wb_cti_i`/`m1_wb_cti_i` in 3: cycle type identifier.
- `m0_wb_bte_i`/`m1_wb_bte_i` in 2: burst type extension.
- `m0_wb_dat_o`/`m1_wb_dat_o` out 32: read data to master.
- `m0_wb_ack_o`/`m1_wb_ack_o` out 1: acknowledge to master.
- `m0_wb_err_o`/`m1_wb_err_o` out 1: error to master.
- `s_wb_adr_o` out 32, `s_wb_sel_o` out 4, `s_wb_we_o` out 1, `s_wb_dat_o` out 32, `s_wb_cyc_o` out 1, `s_wb_stb_o` out 1, `s_wb_cti_o` out 3, `s_wb_bte_o` out 2: muxed request to memory slave.
- `s_wb_dat_i` in 32, `s_wb_ack_i` in 1, `s_wb_err_i` in 1: slave response.
- `gnt_o` out 2: one-hot current grant (`01` = M0, `10` = M1, `00` = idle).

## Operation
- State machine has three states: IDLE, GNT0 and GNT1. A 1-bit `last` register holds the most recently granted master.
- **IDLE**
  - Only M0 `cyc` high: next state GNT0.
  - Only M1 `cyc` high: next state GNT1.
  - Both high: grant the master that is not `last`.
  - Neither high: remain in IDLE.
- **GNTx**
  - Held while `mx_wb_cyc_i` is high, regardless of the other master and regardless of `cti` (classic, constant-address and incrementing bursts all stay granted).
  - When `mx_wb_cyc_i` is sampled low: `last` <= x.
  - If the other master's `cyc` is high, go directly to GNT(other). Otherwise go to IDLE.
- **Slave request mux**
  - Slave request outputs are combinational from the granted master.
  - In IDLE, all `s_wb_*` outputs are 0.
- **Response routing**
  - `s_wb_ack_i`, `s_wb_err_i` and `s_wb_dat_i` go only to the granted master.
  - The non-granted master sees `ack`=0, `err`=0 and `dat_o`=0.
- **Non-granted master:** may hold `cyc`/`stb` indefinitely; it is never acknowledged until granted.
- **Slave ack/err with no grant:** ignored and not forwarded.

## Timing
- **Reset values:** state IDLE, `last`=1 (M0 wins the first tie), `gnt_o`=00, all `s_wb_*` and `m*_wb_*_o` outputs 0, watchdog counter 0.
- **Grant latency:** exactly one cycle. A `cyc` sampled at edge N produces `s_wb_cyc_o` high after edge N.
- **Handoff:** zero idle cycles. The master that drops `cyc` at edge N is followed by the other master on the slave bus after edge N.
- **Response path:** `ack`/`err`/`dat` are combinational, adding zero latency on top of the slave's latency.
- **Reset mid-burst:** outputs clear asynchronously. The in-flight transfer is abandoned with no `ack`. On reset release, arbitration restarts from IDLE with `last`=1.
- **Simultaneous release and request:** the master releasing `cyc` in the same cycle the other raises it is handled as a handoff, not a tie.

## Configuration
- **Macro:** `WB_MEM_ARB_WATCHDOG_EN`.
- **When defined, a watchdog counter is added:**
  - Width is the minimum needed to count to `TIMEOUT`.
  - It increments each cycle the granted master's `stb` is high and the slave returns neither `ack` nor `err`.
  - It clears on `ack`, `err`, IDLE or grant change.
- **When the counter reaches `TIMEOUT`:**
  - For one cycle, `mx_wb_err_o` is forced to 1 and `s_wb_cyc_o`/`s_wb_stb_o` are forced to 0.
  - The counter clears.
  - The grant is not revoked.
- **When undefined:** no counter, no `TIMEOUT` logic; a stalled slave stalls the granted master forever.

## Test plan
- **Single master read:** M0 reads `0x0000_0100` and slave acks 2 cycles later with `0xDEADBEEF` -> `s_wb_cyc_o` high 1 cycle after `m0_cyc`, `m0_wb_dat_o`=`0xDEADBEEF` with `m0_ack`, `m1_ack` stays 0.
- **Tie after reset:** M0 and M1 raise `cyc` in the same cycle -> `gnt_o`=01. After M0 drops `cyc`, `gnt_o`=10 on the next edge with no idle cycle.
- **Round-robin:** M1 completes, then both request simultaneously -> M0 granted. After M0 completes and both request again -> M1 granted.
- **Incrementing burst:** M1 issues a 4-beat burst (`cti`=010, 010, 010, 111) to `0x200`..`0x20C` while M0 requests -> grant stays 10 for all 4 acks. M0 gets no `ack` until M1 `cyc` drops.
- **Reset mid-burst:** assert `wb_rst_n`=0 during beat 2 of an M0 burst -> all outputs 0 immediately, `gnt_o`=00. After release, an M1 request is granted first only if M0 is idle.
- **Watchdog (`WB_MEM_ARB_WATCHDOG_EN`, `TIMEOUT`=16):** M0 `stb` with a silent slave -> `m0_wb_err_o` pulses exactly once, 16 cycles after the first `stb` cycle. `s_wb_stb_o` is low that cycle; no pulse when built without the macro.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone B3 round-robin arbiter in front of a single memory slave.
// Optional stall watchdog is enabled with `define WB_MEM_ARB_WATCHDOG_EN (parameter TIMEOUT).
module wb_mem_arbiter
`ifdef WB_MEM_ARB_WATCHDOG_EN
#(
  parameter int unsigned TIMEOUT = 256
)
`endif
(
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic [2:0]  m0_wb_cti_i,
  input  logic [1:0]  m0_wb_bte_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic [2:0]  m1_wb_cti_i,
  input  logic [1:0]  m1_wb_bte_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic [2:0]  s_wb_cti_o,
  output logic [1:0]  s_wb_bte_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_wd_fire;

  assign w_gnt0 = (r_state == S_GNT0);
  assign w_gnt1 = (r_state == S_GNT1);
  assign gnt_o  = {w_gnt1, w_gnt0};

  // r_last names the master that most recently finished; it loses the next tie.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_wb_cyc_i && m1_wb_cyc_i) r_state <= r_last ? S_GNT0 : S_GNT1;
          else if (m0_wb_cyc_i)           r_state <= S_GNT0;
          else if (m1_wb_cyc_i)           r_state <= S_GNT1;
        end
        S_GNT0: begin
          if (!m0_wb_cyc_i) begin
            r_last  <= 1'b0;
            r_state <= m1_wb_cyc_i ? S_GNT1 : S_IDLE;
          end
        end
        S_GNT1: begin
          if (!m1_wb_cyc_i) begin
            r_last  <= 1'b1;
            r_state <= m0_wb_cyc_i ? S_GNT0 : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    s_wb_dat_o = '0;
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_cti_o = '0;
    s_wb_bte_o = '0;
    if (w_gnt0) begin
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_sel_o = m0_wb_sel_i;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_dat_o = m0_wb_dat_i;
      s_wb_cyc_o = m0_wb_cyc_i & ~w_wd_fire;
      s_wb_stb_o = m0_wb_stb_i & ~w_wd_fire;
      s_wb_cti_o = m0_wb_cti_i;
      s_wb_bte_o = m0_wb_bte_i;
    end else if (w_gnt1) begin
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_sel_o = m1_wb_sel_i;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_dat_o = m1_wb_dat_i;
      s_wb_cyc_o = m1_wb_cyc_i & ~w_wd_fire;
      s_wb_stb_o = m1_wb_stb_i & ~w_wd_fire;
      s_wb_cti_o = m1_wb_cti_i;
      s_wb_bte_o = m1_wb_bte_i;
    end
  end

  assign m0_wb_dat_o = w_gnt0 ? s_wb_dat_i : 32'd0;
  assign m0_wb_ack_o = w_gnt0 & s_wb_ack_i;
  assign m0_wb_err_o = w_gnt0 & (s_wb_err_i | w_wd_fire);
  assign m1_wb_dat_o = w_gnt1 ? s_wb_dat_i : 32'd0;
  assign m1_wb_ack_o = w_gnt1 & s_wb_ack_i;
  assign m1_wb_err_o = w_gnt1 & (s_wb_err_i | w_wd_fire);

`ifdef WB_MEM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          w_cur_cyc;
  logic          w_cur_stb;

  assign w_cur_cyc = (w_gnt0 & m0_wb_cyc_i) | (w_gnt1 & m1_wb_cyc_i);
  assign w_cur_stb = (w_gnt0 & m0_wb_stb_i) | (w_gnt1 & m1_wb_stb_i);
  assign w_wd_fire = (r_wd_cnt == CW'(TIMEOUT));

  // Dropping cyc while granted is exactly when the grant changes, so it clears too.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_cur_cyc || s_wb_ack_i || s_wb_err_i || w_wd_fire) begin
      r_wd_cnt <= '0;
    end else if (w_cur_stb) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus a randomized run
// compared against a round-robin ownership model.
module tb_wb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic        mwe  [2];
  logic        mcyc [2];
  logic        mstb [2];
  logic [2:0]  mcti [2];
  logic [1:0]  mbte [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  gnt;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk = ~wb_clk;

`ifdef WB_MEM_ARB_WATCHDOG_EN
  wb_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
`else
  wb_mem_arbiter dut (
`endif
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_wb_adr_i(madr[0]), .m0_wb_sel_i(msel[0]), .m0_wb_we_i(mwe[0]), .m0_wb_dat_i(mdat[0]),
    .m0_wb_cyc_i(mcyc[0]), .m0_wb_stb_i(mstb[0]), .m0_wb_cti_i(mcti[0]), .m0_wb_bte_i(mbte[0]),
    .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o), .m0_wb_err_o(m0_err_o),
    .m1_wb_adr_i(madr[1]), .m1_wb_sel_i(msel[1]), .m1_wb_we_i(mwe[1]), .m1_wb_dat_i(mdat[1]),
    .m1_wb_cyc_i(mcyc[1]), .m1_wb_stb_i(mstb[1]), .m1_wb_cti_i(mcti[1]), .m1_wb_bte_i(mbte[1]),
    .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o), .m1_wb_err_o(m1_err_o),
    .s_wb_adr_o(s_adr), .s_wb_sel_o(s_sel), .s_wb_we_o(s_we), .s_wb_dat_o(s_dat_o),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_cti_o(s_cti), .s_wb_bte_o(s_bte),
    .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .gnt_o(gnt)
  );

  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic clear_inputs;
    for (int m = 0; m < 2; m++) begin
      madr[m] = '0; mdat[m] = '0; msel[m] = '0; mwe[m] = 1'b0;
      mcyc[m] = 1'b0; mstb[m] = 1'b0; mcti[m] = '0; mbte[m] = '0;
    end
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    wb_rst_n = 1'b0;
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mcyc[1] = 1'b1; mstb[1] = 1'b1;
    madr[0] = 32'h1234_5678; s_ack = 1'b1; s_err = 1'b1; s_dat_i = 32'hCAFE_F00D;
    repeat (3) tick();
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    checks++;
    if ({s_adr, s_sel, s_we, s_dat_o, s_cyc, s_stb, s_cti, s_bte} !== 76'd0) begin
      failures++; $display("FAIL reset_slave_outs got=%h want=0", {s_adr, s_sel, s_we, s_dat_o, s_cyc, s_stb, s_cti, s_bte});
    end
    checks++;
    if ({m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o} !== 68'd0) begin
      failures++; $display("FAIL reset_master_outs got=%h want=0", {m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o});
    end
    clear_inputs();
    wb_rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL reset_idle_after got=%b want=00", gnt); end
  endtask

  task automatic test_tie_handoff;
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h0000_0040;
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 32'h0000_0080;
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL tie_latency s_cyc got=%b want=0", s_cyc); end
    tick();
    checks++;
    if (gnt !== 2'b01 || s_adr !== 32'h40) begin
      failures++; $display("FAIL tie_first gnt=%b adr=%h want gnt=01 adr=40", gnt, s_adr);
    end
    s_ack = 1'b1; s_dat_i = 32'h1111_2222;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1111_2222 || m1_ack_o !== 1'b0 || m1_dat_o !== 32'd0) begin
      failures++; $display("FAIL tie_route m0_ack=%b m0_dat=%h m1_ack=%b m1_dat=%h want 1 11112222 0 0",
                           m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o);
    end
    s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b10 || s_cyc !== 1'b1 || s_adr !== 32'h80) begin
      failures++; $display("FAIL tie_handoff gnt=%b s_cyc=%b adr=%h want 10 1 80", gnt, s_cyc, s_adr);
    end
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL tie_release gnt=%b want=00", gnt); end
  endtask

  task automatic test_round_robin;
    mcyc[0] = 1'b1; mcyc[1] = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL rr_after_m1 gnt=%b want=01", gnt); end
    mcyc[0] = 1'b0; mcyc[1] = 1'b0;
    tick();
    mcyc[0] = 1'b1; mcyc[1] = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL rr_after_m0 gnt=%b want=10", gnt); end
    mcyc[0] = 1'b0; mcyc[1] = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    madr[0] = 32'h0000_0100; msel[0] = 4'hF; mwe[0] = 1'b0; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin failures++; $display("FAIL read_pre_grant s_cyc=%b want=0", s_cyc); end
    tick();
    checks++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h100 || s_sel !== 4'hF) begin
      failures++; $display("FAIL read_request s_cyc=%b adr=%h sel=%h want 1 100 f", s_cyc, s_adr, s_sel);
    end
    tick();
    checks++;
    if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL read_no_early_ack got=%b want=0", m0_ack_o); end
    tick();
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0) begin
      failures++; $display("FAIL read_data m0_ack=%b m0_dat=%h m1_ack=%b want 1 deadbeef 0", m0_ack_o, m0_dat_o, m1_ack_o);
    end
    s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL read_release gnt=%b want=00", gnt); end
  endtask

  task automatic test_burst;
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    madr[1] = 32'h200; mcti[1] = 3'b010; mcyc[1] = 1'b1; mstb[1] = 1'b1;
    tick();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h300;
    for (int i = 0; i < 4; i++) begin
      exp_adr = 32'h200 + 32'(4 * i);
      exp_cti = (i == 3) ? 3'b111 : 3'b010;
      madr[1] = exp_adr; mcti[1] = exp_cti;
      s_ack = 1'b1; s_dat_i = $urandom;
      #1;
      checks++;
      if (gnt !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || s_adr !== exp_adr || s_cti !== exp_cti) begin
        failures++; $display("FAIL burst_beat%0d gnt=%b m1_ack=%b m0_ack=%b adr=%h cti=%b want 10 1 0 %h %b",
                             i, gnt, m1_ack_o, m0_ack_o, s_adr, s_cti, exp_adr, exp_cti);
      end
      tick();
    end
    s_ack = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    tick();
    s_ack = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b01 || m0_ack_o !== 1'b1 || s_adr !== 32'h300) begin
      failures++; $display("FAIL burst_handoff gnt=%b m0_ack=%b adr=%h want 01 1 300", gnt, m0_ack_o, s_adr);
    end
    s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst;
    madr[0] = 32'h400; mcti[0] = 3'b010; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    tick();
    s_ack = 1'b1; s_dat_i = 32'hAAAA_5555;
    tick();
    madr[0] = 32'h404;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL rst_beat2_pre got=%b want=1", m0_ack_o); end
    wb_rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== 32'd0 || m0_ack_o !== 1'b0 || m0_dat_o !== 32'd0) begin
      failures++; $display("FAIL rst_async_clear gnt=%b cyc=%b stb=%b adr=%h ack=%b dat=%h want all 0",
                           gnt, s_cyc, s_stb, s_adr, m0_ack_o, m0_dat_o);
    end
    s_ack = 1'b0;
    mcyc[1] = 1'b1;
    tick();
    wb_rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL rst_tie_restart gnt=%b want=01", gnt); end
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0;
    tick();
    mcyc[1] = 1'b1;
    tick();
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL rst_m1_alone gnt=%b want=10", gnt); end
    mcyc[1] = 1'b0;
    tick();
  endtask

  task automatic test_watchdog;
    int pulses;
    int exp_pulses;
    logic exp_fire;
    pulses = 0;
`ifdef WB_MEM_ARB_WATCHDOG_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    madr[0] = 32'h500; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      exp_fire = (exp_pulses == 1) && (k == TIMEOUT + 1);
      if (m0_err_o) pulses++;
      checks++;
      if (m0_err_o !== exp_fire || s_stb !== !exp_fire || gnt !== 2'b01) begin
        failures++; $display("FAIL wdog_cycle%0d err=%b stb=%b gnt=%b want %b %b 01", k, m0_err_o, s_stb, gnt, exp_fire, !exp_fire);
      end
      tick();
    end
    checks++;
    if (pulses != exp_pulses) begin failures++; $display("FAIL wdog_pulses got=%0d want=%0d", pulses, exp_pulses); end
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    tick();
  endtask

  task automatic test_random;
    int owner;
    int last;
    int wd;
    bit fire;
    bit quiet;
    logic [75:0] exp_s;
    logic [67:0] exp_r;
    logic [1:0]  exp_g;
    clear_inputs();
    wb_rst_n = 1'b0;
    #2;
    wb_rst_n = 1'b1;
    owner = -1; last = 1; wd = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
`ifdef WB_MEM_ARB_WATCHDOG_EN
      fire = (owner >= 0) && (wd == TIMEOUT);
      if (owner < 0 || !mcyc[owner] || s_ack || s_err || fire) wd = 0;
      else if (mstb[owner]) wd++;
`endif
      if (!(owner >= 0 && mcyc[owner])) begin
        if (owner >= 0) last = owner;
        if (mcyc[0] && mcyc[1]) owner = 1 - last;
        else if (mcyc[0]) owner = 0;
        else if (mcyc[1]) owner = 1;
        else owner = -1;
      end
      quiet = ((i / 100) % 2) == 1;
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(quiet ? 31 : 3) == 0) mcyc[m] = ~mcyc[m];
        mstb[m] = mcyc[m] & 1'($urandom_range(1));
        madr[m] = $urandom; mdat[m] = $urandom;
        msel[m] = 4'($urandom_range(15)); mwe[m] = 1'($urandom_range(1));
        mcti[m] = 3'($urandom_range(7)); mbte[m] = 2'($urandom_range(3));
      end
      s_ack = !quiet && ($urandom_range(2) == 0);
      s_err = !quiet && ($urandom_range(15) == 0);
      s_dat_i = $urandom;
      #1;
      fire = 1'b0;
`ifdef WB_MEM_ARB_WATCHDOG_EN
      fire = (owner >= 0) && (wd == TIMEOUT);
`endif
      exp_s = '0; exp_r = '0; exp_g = 2'b00;
      if (owner >= 0) begin
        exp_g = (owner == 0) ? 2'b01 : 2'b10;
        exp_s = {madr[owner], msel[owner], mwe[owner], mdat[owner], mcyc[owner] & ~fire,
                 mstb[owner] & ~fire, mcti[owner], mbte[owner]};
        if (owner == 0) exp_r = {s_dat_i, s_ack, s_err | fire, 34'd0};
        else            exp_r = {34'd0, s_dat_i, s_ack, s_err | fire};
      end
      checks++;
      if (gnt !== exp_g) begin failures++; $display("FAIL rand_gnt cyc%0d got=%b want=%b", i, gnt, exp_g); end
      checks++;
      if ({s_adr, s_sel, s_we, s_dat_o, s_cyc, s_stb, s_cti, s_bte} !== exp_s) begin
        failures++; $display("FAIL rand_slave cyc%0d got=%h want=%h", i, {s_adr, s_sel, s_we, s_dat_o, s_cyc, s_stb, s_cti, s_bte}, exp_s);
      end
      checks++;
      if ({m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o} !== exp_r) begin
        failures++; $display("FAIL rand_resp cyc%0d got=%h want=%h", i, {m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o}, exp_r);
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_tie_handoff();
    test_round_robin();
    test_single_read();
    test_burst();
    test_reset_mid_burst();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
